// File: rtl/instr_encoder.sv
// Instruction field encoder that packs R/I/J/NOOP formats into 32-bit words.
// Each word is buffered in a small FIFO together with its byte address.
// Optional macro INSTR_ENCODER_NOOP_FILL_EN: an illegal opcode enqueues a NOOP instead of being dropped.
module instr_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rs,
    input  logic [3:0]        in_rt,
    input  logic [3:0]        in_func,
    input  logic [15:0]       in_imm,
    input  logic [19:0]       in_offs,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_bad_op,
    output logic [4:0]        level
);
    localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

    logic [ADDR_W+31:0] mem [0:FIFO_DEPTH-1];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [ADDR_W-1:0]  cnt, base;
    logic [31:0]        word;
    logic               illegal, accept, push, pop;

    always_comb begin
        word    = 32'hF000_0000;
        illegal = 1'b0;
        case (in_op)
            4'd0, 4'd2:                          word = {in_op, in_rd, in_rs, in_rt, 12'h000, in_func};
            4'd1, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11: word = {in_op, in_rd, in_rs, 4'h0, in_imm};
            4'd4, 4'd5, 4'd6, 4'd7:              word = {in_op, in_rd, in_rs, in_offs};
            4'd15:                               word = 32'hF000_0000;
            default:                             illegal = 1'b1;
        endcase
    end

    // in_ready depends only on the registered level, never on out_ready
    assign in_ready  = (level != DEPTH_L);
    assign out_valid = (level != 5'd0);
    assign accept    = in_valid && in_ready && !rst;
`ifdef INSTR_ENCODER_NOOP_FILL_EN
    assign push      = accept;
`else
    assign push      = accept && !illegal;
`endif
    assign pop       = out_valid && out_ready;
    assign base      = addr_load ? addr_value : cnt;

    assign out_word  = out_valid ? mem[rd_ptr][ADDR_W+31:ADDR_W] : 32'h0;
    assign out_addr  = out_valid ? mem[rd_ptr][ADDR_W-1:0] : '0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {word, base};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= 5'd0;
            cnt        <= '0;
            err_bad_op <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 5'd1;
                2'b01:   level <= level - 5'd1;
                default: level <= level;
            endcase
            // a dropped illegal op still honours a same-cycle addr_load
            cnt        <= push ? base + ADDR_W'(4) : base;
            err_bad_op <= accept && illegal;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized + directed bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0, in_ready;
    logic [3:0]        in_op = '0, in_rd = '0, in_rs = '0, in_rt = '0, in_func = '0;
    logic [15:0]       in_imm = '0;
    logic [19:0]       in_offs = '0;
    logic              addr_load = 1'b0;
    logic [ADDR_W-1:0] addr_value = '0;
    logic              out_valid, out_ready = 1'b0;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;
    logic              err_bad_op;
    logic [4:0]        level;

    instr_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_func(in_func),
        .in_imm(in_imm), .in_offs(in_offs), .addr_load(addr_load), .addr_value(addr_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr),
        .err_bad_op(err_bad_op), .level(level)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [31:0] w; logic [ADDR_W-1:0] a; } ent_t;
    ent_t              q[$];
    logic [ADDR_W-1:0] m_cnt = '0;
    bit                m_err = 1'b0;

    function automatic logic [31:0] enc(input logic [3:0] op, rd, rs, rt, fn,
                                        input logic [15:0] imm, input logic [19:0] offs);
        int o = int'(op);
        if (o == 0 || o == 2)                 return {op, rd, rs, rt, 12'h000, fn};
        if (o == 1 || o == 3 || (o >= 8 && o <= 11)) return {op, rd, rs, 4'h0, imm};
        if (o >= 4 && o <= 7)                 return {op, rd, rs, offs};
        return 32'hF000_0000;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_cnt = '0;
            m_err = 1'b0;
        end else begin
            bit acc, bad, psh, pp;
            logic [ADDR_W-1:0] b;
            acc = in_valid && (q.size() != DEPTH);
            pp  = (q.size() != 0) && out_ready;
            bad = (in_op >= 4'd12 && in_op <= 4'd14);
`ifdef INSTR_ENCODER_NOOP_FILL_EN
            psh = acc;
`else
            psh = acc && !bad;
`endif
            b = addr_load ? addr_value : m_cnt;
            m_err = acc && bad;
            if (pp) void'(q.pop_front());
            if (psh) q.push_back({enc(in_op, in_rd, in_rs, in_rt, in_func, in_imm, in_offs), b});
            m_cnt = psh ? b + 16'd4 : b;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 48'(out_valid), 48'(q.size() != 0));
            chk("in_ready",  48'(in_ready),  48'(q.size() != DEPTH));
            chk("level",     48'(level),     48'(q.size()));
            chk("err_bad_op",48'(err_bad_op),48'(m_err));
            chk("out_word",  48'(out_word),  q.size() != 0 ? 48'(q[0].w) : 48'h0);
            chk("out_addr",  48'(out_addr),  q.size() != 0 ? 48'(q[0].a) : 48'h0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic fields(input logic [3:0] op, rd, rs, rt, fn,
                          input logic [15:0] imm, input logic [19:0] offs);
        in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_func = fn;
        in_imm = imm; in_offs = offs;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset in_ready", 48'(in_ready), 48'h1);
        chk("reset level", 48'(level), 48'h0);
        chk("reset out_valid", 48'(out_valid), 48'h0);

        // ARITH basic encoding
        out_ready = 1'b1;
        fields(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 16'h0, 20'h0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("arith word", 48'(out_word), 48'h0123_0004);
        chk("arith addr", 48'(out_addr), 48'h0);
        tick();

        // LOAD then JAL
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        fields(4'd8, 4'd5, 4'd6, 4'd0, 4'd0, 16'hBEEF, 20'h0);
        tick();
        fields(4'd6, 4'd15, 4'd3, 4'd0, 4'd0, 16'h0, 20'hABCDE);
        tick();
        in_valid = 1'b0;
        chk("load word", 48'(out_word), 48'h8560_BEEF);
        chk("load addr", 48'(out_addr), 48'h0);
        out_ready = 1'b1;
        tick();
        chk("jal word", 48'(out_word), 48'h6F3A_BCDE);
        chk("jal addr", 48'(out_addr), 48'h4);
        tick();

        // backpressure fill and in-order drain
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fields(4'd0, 4'(i + 1), 4'd0, 4'd0, 4'd0, 16'h0, 20'h0);
            tick();
            if (i == 3) begin
                chk("full in_ready", 48'(in_ready), 48'h0);
                chk("full level", 48'(level), 48'h4);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain word", 48'(out_word), 48'({4'h0, 4'(i + 1), 24'h0}));
            chk("drain addr", 48'(out_addr), 48'(4 * i));
            tick();
        end
        chk("drain empty", 48'(out_valid), 48'h0);

        // illegal opcode
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        fields(4'd13, 4'd1, 4'd1, 4'd1, 4'd1, 16'h1, 20'h1);
        tick();
        in_valid = 1'b0;
        chk("bad op pulse", 48'(err_bad_op), 48'h1);
`ifdef INSTR_ENCODER_NOOP_FILL_EN
        chk("bad op fill word", 48'(out_word), 48'hF000_0000);
        chk("bad op fill valid", 48'(out_valid), 48'h1);
`else
        chk("bad op dropped", 48'(out_valid), 48'h0);
`endif
        tick();
        chk("bad op pulse end", 48'(err_bad_op), 48'h0);

        // address load and wrap
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        addr_load = 1'b1;
        addr_value = 16'hFFFC;
        fields(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 20'h0);
        tick();
        addr_load = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("load addr first", 48'(out_addr), 48'hFFFC);
        out_ready = 1'b1;
        tick();
        chk("load addr wrap", 48'(out_addr), 48'h0);
        tick();

        // reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("mid rst out_valid", 48'(out_valid), 48'h0);
        chk("mid rst level", 48'(level), 48'h0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mid rst next addr", 48'(out_addr), 48'h0);
        out_ready = 1'b1;
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            addr_load  = ($urandom_range(0, 15) == 0);
            addr_value = 16'($urandom);
            fields(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                   16'($urandom), 20'($urandom));
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        addr_load = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries, power of two, 2 to 16.
REQ-002 SHALL have parameter ADDR_W, default 16, width of the word byte address.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  field set presented.
REQ-006 SHALL have port in_ready  output  1  field set accepted this cycle when high with in_valid.
REQ-007 SHALL have ports in_op, in_rd, in_rs, in_rt, in_func  input  4 each  instruction fields.
REQ-008 SHALL have ports in_imm  input  16 and in_offs  input  20  immediate and jump offset.
REQ-009 SHALL have port addr_load  input  1 and addr_value  input  ADDR_W  address counter reload.
REQ-010 SHALL have port out_valid  output  1 and out_ready  input  1  output handshake.
REQ-011 SHALL have port out_word  output  32 and out_addr  output  ADDR_W  encoded word and its byte address.
REQ-012 SHALL have port err_bad_op  output  1  one-cycle pulse on an illegal opcode.
REQ-013 SHALL have port level  output  5  current buffer occupancy.

Function
REQ-014 SHALL classify opcodes: R = ARITH(0), TEST(2); I = AR_IM(1), TS_IM(3), LOAD(8), STORE(9), BEQZ(10), BNEZ(11); J = JUMP(4), JR(5), JAL(6), JALR(7); NOOP = 15; opcodes 12-14 illegal.
REQ-015 SHALL pack every format with op[31:28], rd[27:24], rs[23:20].
REQ-016 SHALL pack R format as rt[19:16], zero[15:4], func[3:0].
REQ-017 SHALL pack I format as zero[19:16], imm[15:0].
REQ-018 SHALL pack J format as offs[19:0].
REQ-019 SHALL encode NOOP as 32'hF000_0000 and ignore all other fields.
REQ-020 SHALL drive in_ready = (level != FIFO_DEPTH), from registered state only, with no combinational path from out_ready.
REQ-021 SHALL, on accept of a legal opcode, push {word, address counter} into the buffer and advance the counter by 4, modulo 2^ADDR_W.
REQ-022 SHALL present a pushed entry on out_valid no earlier than the cycle after the accept (1-cycle minimum latency, no bypass).
REQ-023 SHALL pop the head entry when out_valid && out_ready, and hold out_word/out_addr stable while out_valid && !out_ready.
REQ-024 SHALL, on simultaneous push and pop, leave level unchanged and preserve order.
REQ-025 SHALL, when addr_load is high, load the counter with addr_value; a same-cycle accept uses addr_value as its address and leaves the counter at addr_value+4.
REQ-026 SHALL, when out_valid is low, drive out_word and out_addr to zero.
REQ-027 SHALL pulse err_bad_op for exactly one cycle, the cycle after an accept carrying opcode 12-14.

Reset
REQ-028 SHALL, on rst, clear the buffer, level, counter, out_valid and err_bad_op to 0, and drive out_word/out_addr to 0 and in_ready to 1 on the following cycle.
REQ-029 SHALL, when rst is asserted mid-stream, discard all buffered entries and ignore any in_valid in that cycle.

Configuration
REQ-030 SHALL support macro INSTR_ENCODER_NOOP_FILL_EN.
REQ-031 SHALL, with the macro defined, enqueue 32'hF000_0000 for an illegal opcode at the current address and advance the counter.
REQ-032 SHALL, without the macro, consume and drop an illegal opcode without enqueuing it or advancing the counter.
REQ-033 SHALL pulse err_bad_op on an illegal opcode in both configurations.

Verification
REQ-034 SHALL test: reset, then ARITH rd=1 rs=2 rt=3 func=4 -> out_word 32'h0123_0004, out_addr 0 one cycle later.
REQ-035 SHALL test: LOAD rd=5 rs=6 imm=16'hBEEF, then JAL rd=15 offs=20'hABCDE -> 32'h8560_BEEF @0, then 32'h6F?A_BCDE with rs in [23:20] @4.
REQ-036 SHALL test: out_ready held low with 5 pushes at FIFO_DEPTH=4 -> in_ready low after the 4th push, level=4, and all 4 words drained in order once out_ready rises.
REQ-037 SHALL test: opcode 13 -> err_bad_op one pulse; nothing output without the macro; 32'hF000_0000 output with the macro.
REQ-038 SHALL test: addr_load with addr_value=16'hFFFC plus a same-cycle accept, then a second accept -> addresses 16'hFFFC and 16'h0000 (wrap).
REQ-039 SHALL test: rst with 3 entries buffered -> out_valid=0 and level=0 on the next cycle, and the next output address is 0.
